// File: rtl/x2050bcseq.sv
// Byte-counter sequencer for storage-to-storage operand scans.
// Steps BC once per operand byte and requests a new storage word each time BC wraps.
module x2050bcseq #(
    parameter int W  = 2,
    parameter int LW = 8
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_ros_advance,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic [W-1:0]  i_addr_lo,
    input  logic [LW-1:0] i_len,
    input  logic          i_dir,
    input  logic [W-1:0]  i_bc,
    input  logic          i_word_ack,
    output logic          o_bc_sel,
    output logic [1:0]    o_bc_up,
    output logic          o_bc_wstb,
    output logic [W-1:0]  o_bc_newvalue,
    output logic          o_byte_valid,
    output logic          o_word_req,
    output logic          o_busy,
    output logic          o_done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_STEP = 3'd2,
        S_WORD = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [W-1:0]  BC_MAX  = {W{1'b1}};
    localparam logic [W-1:0]  BC_ZERO = {W{1'b0}};
    localparam logic [LW-1:0] REM_ONE = {{(LW-1){1'b0}}, 1'b1};

    state_t        state;
    state_t        state_nx;
    logic [LW-1:0] rem;
    logic [LW-1:0] rem_nx;
    logic          dir;
    logic          dir_nx;
    logic [W-1:0]  addr;
    logic [W-1:0]  addr_nx;
    logic          boundary;

    // The last byte of a word depends on scan direction.
    always_comb begin
        if (dir) begin
            boundary = (i_bc == BC_ZERO);
        end else begin
            boundary = (i_bc == BC_MAX);
        end
    end

    // Next-state and working-register update; abort beats the ROS-gated path.
    always_comb begin
        state_nx = state;
        rem_nx   = rem;
        dir_nx   = dir;
        addr_nx  = addr;
        if (i_abort) begin
            state_nx = S_IDLE;
            rem_nx   = {LW{1'b0}};
        end else if (i_ros_advance) begin
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        state_nx = S_LOAD;
                        rem_nx   = i_len;
                        dir_nx   = i_dir;
                        addr_nx  = i_addr_lo;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
                S_LOAD: state_nx = S_STEP;
                S_STEP: begin
                    if (rem == {LW{1'b0}}) begin
                        state_nx = S_DONE;
                    end else begin
                        rem_nx = rem - REM_ONE;
                        if (boundary) begin
                            state_nx = S_WORD;
                        end else begin
                            state_nx = S_STEP;
                        end
                    end
                end
                S_WORD: begin
                    if (i_word_ack) begin
                        state_nx = S_STEP;
                    end else begin
                        state_nx = S_WORD;
                    end
                end
                S_DONE:  state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end else begin
            state_nx = state;
        end
    end

    // State registers plus outputs decoded from the next state, so they hold for a full ROS cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= S_IDLE;
            rem           <= {LW{1'b0}};
            dir           <= 1'b0;
            addr          <= {W{1'b0}};
            o_bc_sel      <= 1'b0;
            o_bc_up       <= 2'd0;
            o_bc_wstb     <= 1'b0;
            o_bc_newvalue <= {W{1'b0}};
            o_byte_valid  <= 1'b0;
            o_word_req    <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            state         <= state_nx;
            rem           <= rem_nx;
            dir           <= dir_nx;
            addr          <= addr_nx;
            o_bc_sel      <= (state_nx == S_STEP) && (rem_nx != {LW{1'b0}});
            o_bc_up       <= (state_nx == S_STEP) ? (dir_nx ? 2'd2 : 2'd3) : 2'd0;
            o_bc_wstb     <= (state_nx == S_LOAD);
            o_bc_newvalue <= (state_nx == S_LOAD) ? addr_nx : {W{1'b0}};
            o_byte_valid  <= (state_nx == S_STEP);
            o_word_req    <= (state_nx == S_WORD);
            o_busy        <= (state_nx != S_IDLE);
            o_done        <= (state_nx == S_DONE);
        end
    end

endmodule
